// File: rtl/i2s_tx_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2s_tx_serializer_if                                      |
// | Brief    : Stereo sample valid/ready handshake into the I2S TX path. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface i2s_tx_serializer_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2s_tx_serializer                                         |
// | Brief    : I2S transmit serializer, MSB-first, one-BCLK LRCK delay,  |
// |            single stereo pair pending buffer.                        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic           clk_in,
    input  wire logic           reset,
    input  wire logic           bclk_in,
    input  wire logic           lrclk_in,
    i2s_tx_serializer_if.slave  sample_if,
    output logic                sdata_out,
    output logic                underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] c_BITS = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LEFT  = 2'd1;
    localparam logic [1:0] c_ST_RIGHT = 2'd2;

    logic [1:0]            r_state;
    logic                  r_bclk_d;
    logic                  r_lr_q;
    logic                  r_load_next;
    logic                  r_pend_full;
    logic [DATA_WIDTH-1:0] r_pend_l;
    logic [DATA_WIDTH-1:0] r_pend_r;
    logic [DATA_WIDTH-1:0] r_hold_r;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_sdata;
    logic                  r_underrun;

    logic                  w_bfall;
    logic                  w_boundary;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_load_left;
    logic [DATA_WIDTH-1:0] w_load_word;

    assign w_bfall     = r_bclk_d & ~bclk_in;
    assign w_boundary  = w_bfall & (lrclk_in != r_lr_q);
    assign w_accept    = sample_if.sample_valid & ~r_pend_full;
    assign w_load      = w_bfall & r_load_next;
    assign w_load_left = w_load & (r_state == c_ST_LEFT);

    // A left load with nothing pending sends silence on both channels.
    assign w_load_word = (r_state == c_ST_LEFT) ? (r_pend_full ? r_pend_l : '0) : r_hold_r;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bclk_d    <= 1'b0;
            r_lr_q      <= 1'b0;
            r_load_next <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_l    <= '0;
            r_pend_r    <= '0;
            r_hold_r    <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_bclk_d   <= bclk_in;
            r_underrun <= 1'b0;

            // The load uses the pre-accept buffer state, so an accept on the
            // load cycle is kept for the following frame.
            if (w_accept) begin
                r_pend_l    <= sample_if.left_data;
                r_pend_r    <= sample_if.right_data;
                r_pend_full <= 1'b1;
            end else if (w_load_left && r_pend_full) begin
                r_pend_full <= 1'b0;
            end

            if (w_bfall) begin
                r_lr_q <= lrclk_in;

                if (w_load) begin
                    r_load_next <= 1'b0;
                    r_sdata     <= w_load_word[DATA_WIDTH-1];
                    r_shift     <= w_load_word << 1;
                    r_bit_cnt   <= c_ONE;
                    if (w_load_left) begin
                        r_hold_r   <= r_pend_full ? r_pend_r : '0;
                        r_underrun <= ~r_pend_full;
                    end
                end else if ((r_state != c_ST_IDLE) && (r_bit_cnt < c_BITS)) begin
                    r_sdata   <= r_shift[DATA_WIDTH-1];
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + c_ONE;
                end else begin
                    r_sdata <= 1'b0;
                end

                // Right-channel edges are ignored until a left frame has started.
                if (w_boundary) begin
                    if (!lrclk_in) begin
                        r_state     <= c_ST_LEFT;
                        r_load_next <= 1'b1;
                    end else if (r_state != c_ST_IDLE) begin
                        r_state     <= c_ST_RIGHT;
                        r_load_next <= 1'b1;
                    end
                end
            end
        end
    end

    assign sample_if.sample_ready = ~r_pend_full;
    assign sdata_out              = r_sdata;
    assign underrun               = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_i2s_tx_serializer                                      |
// | Brief    : Randomized scoreboard bench for i2s_tx_serializer.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_i2s_tx_serializer;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic bclk   = 1'b1;
    logic lrclk  = 1'b0;
    logic sdata_out;
    logic underrun;

    i2s_tx_serializer_if #(.DATA_WIDTH(DW)) sif ();

    i2s_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .bclk_in   (bclk),
        .lrclk_in  (lrclk),
        .sample_if (sif.slave),
        .sdata_out (sdata_out),
        .underrun  (underrun)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    bit gen_en = 1'b0;
    bit mon_en = 1'b0;
    bit chk_en = 1'b0;
    bit load_left_evt = 1'b0;
    bit pre_load = 1'b0;
    int phase = 0;
    int bit_idx = 0;
    int half_len = 16;
    int half_req = 16;

    frame_t        exp_q[$];
    bit            m_full = 1'b0;
    logic [DW-1:0] m_l = '0;
    logic [DW-1:0] m_r = '0;
    bit            exp_underrun = 1'b0;

    bit            mon_armed = 1'b0;
    logic          mon_lr = 1'b0;
    int            mon_pos = 0;
    logic [DW-1:0] mon_word = '0;
    bit            mon_pad_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [31:0] v;
        v = $urandom();
        return v[DW-1:0];
    endfunction

    // BCLK = clk/16, LRCK half = half_len BCLKs; inputs change on negedge.
    initial begin
        wait (gen_en);
        forever begin
            @(negedge clk_in);
            load_left_evt = 1'b0;
            pre_load      = 1'b0;
            if (phase == 0) begin
                bclk = 1'b0;
                if (bit_idx == 0) begin
                    lrclk = ~lrclk;
                    if (!lrclk) half_len = half_req;
                end
                load_left_evt = (bit_idx == 1) && !lrclk;
                bit_idx = (bit_idx + 1) % half_len;
            end else if (phase == 8) begin
                bclk = 1'b1;
            end else if (phase == 15) begin
                pre_load = (bit_idx == 1) && !lrclk;
            end
            phase = (phase + 1) % 16;
        end
    end

    // Transaction model: one-pair buffer, left frame start consumes it.
    initial begin
        bit pre;
        forever begin
            @(posedge clk_in);
            if (reset) begin
                m_full       = 1'b0;
                exp_underrun = 1'b0;
            end else begin
                pre          = m_full;
                exp_underrun = 1'b0;
                if (load_left_evt) begin
                    if (m_full) begin
                        exp_q.push_back({m_l, m_r});
                        m_full = 1'b0;
                    end else begin
                        exp_q.push_back('0);
                        exp_underrun = 1'b1;
                    end
                end
                if (sif.sample_valid && !pre) begin
                    m_l    = sif.left_data;
                    m_r    = sif.right_data;
                    m_full = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                check("underrun", 32'(underrun), 32'(exp_underrun));
                check("sample_ready", 32'(sif.sample_ready), 32'(!m_full));
            end
        end
    end

    task automatic put_bit(input int slot, input logic b);
        if (slot <= DW) mon_word[DW-slot] = b;
        else if (b) mon_pad_bad = 1'b1;
    endtask

    task automatic finish_half(input logic lr_old, input int slot, input logic b);
        put_bit(slot, b);
        check("half_bits", 32'(slot >= DW), 32'd1);
        check("pad_zero", 32'(mon_pad_bad), 32'd0);
        if (exp_q.size() == 0) begin
            fail_now("no_expected_frame");
        end else if (!lr_old) begin
            check("left_word", 32'(mon_word), 32'(exp_q[0].l));
        end else begin
            check("right_word", 32'(mon_word), 32'(exp_q[0].r));
            void'(exp_q.pop_front());
        end
    endtask

    // Decode I2S on BCLK rising: the bit at the first rise after an LRCK
    // change is the last slot of the previous half.
    initial begin
        logic b;
        forever begin
            @(posedge bclk);
            if (reset || !mon_en) begin
                mon_armed = 1'b0;
                mon_lr    = lrclk;
                mon_pos   = 0;
            end else begin
                b = sdata_out;
                if (lrclk != mon_lr) begin
                    if (mon_armed) finish_half(mon_lr, mon_pos + 1, b);
                    else check("idle_zero", 32'(b), 32'd0);
                    if (!lrclk) mon_armed = 1'b1;
                    mon_lr      = lrclk;
                    mon_pos     = 0;
                    mon_word    = '0;
                    mon_pad_bad = 1'b0;
                end else begin
                    mon_pos++;
                    if (mon_armed) put_bit(mon_pos, b);
                    else check("idle_zero", 32'(b), 32'd0);
                end
            end
        end
    end

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit ok;
        ok = 1'b0;
        @(negedge clk_in);
        sif.left_data    = l;
        sif.right_data   = r;
        sif.sample_valid = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk_in);
            if (sif.sample_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(negedge clk_in);
        sif.sample_valid = 1'b0;
    endtask

    task automatic wait_flag(input bit want_pre);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk_in);
            if (want_pre ? pre_load : load_left_evt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("frame_timeout");
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.left_data    = '0;
        sif.right_data   = '0;
        repeat (3) @(negedge clk_in);
        check("reset_sdata", 32'(sdata_out), 32'd0);
        check("reset_underrun", 32'(underrun), 32'd0);
        check("reset_ready", 32'(sif.sample_ready), 32'd1);
        reset  = 1'b0;
        gen_en = 1'b1;
        mon_en = 1'b1;
        chk_en = 1'b1;

        send_pair(16'hA5F0, 16'h0F5A);
        for (int i = 0; i < 4; i++) send_pair(rnd(), rnd());

        repeat (3 * 512) @(negedge clk_in);

        // Pair offered on the very cycle the left load underruns.
        wait_flag(1'b1);
        @(negedge clk_in);
        sif.left_data    = rnd();
        sif.right_data   = rnd();
        sif.sample_valid = 1'b1;
        @(negedge clk_in);
        sif.sample_valid = 1'b0;
        repeat (700) @(negedge clk_in);

        sif.sample_valid = 1'b1;
        for (int c = 0; c < 4 * 512; c++) begin
            @(negedge clk_in);
            sif.left_data  = rnd();
            sif.right_data = rnd();
        end
        sif.sample_valid = 1'b0;

        half_req = 32;
        send_pair(16'h8001, 16'h7FFF);
        for (int i = 0; i < 2; i++) send_pair(rnd(), rnd());

        wait_flag(1'b0);
        repeat (7 * 16) @(negedge clk_in);
        reset     = 1'b1;
        mon_armed = 1'b0;
        mon_lr    = lrclk;
        mon_pos   = 0;
        exp_q.delete();
        @(negedge clk_in);
        check("midreset_sdata", 32'(sdata_out), 32'd0);
        check("midreset_ready", 32'(sif.sample_ready), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) send_pair(rnd(), rnd());
        repeat (3 * 1024) @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
